// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serialiser with valid/ready load handshake and a one-word
// holding buffer, so back-to-back words go out with no idle bits between them.
//
// state | meaning
// IDLE  | shifter empty, y=0, next accepted word goes straight into sreg
// SHIFT | word in sreg being shifted out, one bit per en-cycle
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    input  logic             en,
    output logic             ready,
    output logic             y,
    output logic             y_valid,
    output logic             first,
    output logic             last,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [WIDTH-1:0] hbuf, hbuf_n;
    logic [WIDTH-1:0] sreg_shifted;
    logic [CW-1:0]    cnt, cnt_n;
    logic             hvalid, hvalid_n;
    logic             active;
    logic             accept;

    assign active = (state == SHIFT);
    assign accept = load && !hvalid;

    // Zero-filled shift toward whichever end drives y.
    assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            sreg   <= '0;
            cnt    <= '0;
            hbuf   <= '0;
            hvalid <= 1'b0;
        end else begin
            state  <= state_n;
            sreg   <= sreg_n;
            cnt    <= cnt_n;
            hbuf   <= hbuf_n;
            hvalid <= hvalid_n;
        end
    end

    always_comb begin
        state_n  = state;
        sreg_n   = sreg;
        cnt_n    = cnt;
        hbuf_n   = hbuf;
        hvalid_n = hvalid;
        case (state)
            IDLE: begin
                if (accept) begin
                    sreg_n  = d;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    if (cnt == CNT_LAST) begin
                        // Word end: buffered word wins over a direct load.
                        cnt_n = '0;
                        if (hvalid) begin
                            sreg_n   = hbuf;
                            hvalid_n = 1'b0;
                        end else if (load) begin
                            sreg_n = d;
                        end else begin
                            sreg_n  = sreg_shifted;
                            state_n = IDLE;
                        end
                    end else begin
                        sreg_n = sreg_shifted;
                        cnt_n  = cnt + CW'(1);
                        if (accept) begin
                            hbuf_n   = d;
                            hvalid_n = 1'b1;
                        end
                    end
                end else if (accept) begin
                    hbuf_n   = d;
                    hvalid_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign ready   = !hvalid;
    assign y       = active ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : 1'b0;
    assign y_valid = active;
    assign first   = active && (cnt == '0);
    assign last    = active && (cnt == CNT_LAST);
    assign busy    = active || hvalid;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: table-driven 4-bit vectors (both bit orders) plus scoreboarded
// 8-bit sequences for back-to-back, stall and mid-word reset.
module tb_piso_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en;
    logic [3:0] d4m, d4l;
    logic       load4m, load4l;
    logic [7:0] d8;
    logic       load8;

    logic ready4m, y4m, yv4m, first4m, last4m, busy4m;
    logic ready4l, y4l, yv4l, first4l, last4l, busy4l;
    logic ready8, y8, yv8, first8, last8, busy8;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_w4m (
        .clk(clk), .rst(rst), .d(d4m), .load(load4m), .en(en),
        .ready(ready4m), .y(y4m), .y_valid(yv4m), .first(first4m), .last(last4m), .busy(busy4m)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_w4l (
        .clk(clk), .rst(rst), .d(d4l), .load(load4l), .en(en),
        .ready(ready4l), .y(y4l), .y_valid(yv4l), .first(first4l), .last(last4l), .busy(busy4l)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_w8 (
        .clk(clk), .rst(rst), .d(d8), .load(load8), .en(en),
        .ready(ready8), .y(y8), .y_valid(yv8), .first(first8), .last(last8), .busy(busy8)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Each entry: {y, first, last} expected for one consumed bit of the 8-bit DUT.
    logic [2:0] exp_q[$];
    logic [2:0] mon_e;

    typedef struct {
        logic       lsb;
        logic [3:0] d;
        logic [3:0] seq;
    } vec4_t;

    vec4_t      tbl[6];
    logic [3:0] exp4, act4;
    int         bt, bgap, blow, vc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send8(input logic [7:0] w);
        int t;
        d8    = w;
        load8 = 1'b1;
        t     = 0;
        while (t < 40) begin
            @(negedge clk);
            if (ready8) break;
            t++;
        end
        if (t >= 40) begin
            n_vec++;
            n_bad++;
            $display("FAIL send8_timeout: ready stayed 0 for word %0h", w);
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: expected bits queued when a load is about to be accepted,
    // popped on every cycle in which the DUT consumes a bit.
    always @(negedge clk) begin
        if (rst && yv8 && en) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL sb_underflow: got y=%0b with no expected bit", y8);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_bit", {29'd0, y8, first8, last8}, {29'd0, mon_e});
            end
        end
        if (rst && load8 && ready8) begin
            for (int i = 0; i < 8; i++)
                exp_q.push_back({d8[7-i], (i == 0), (i == 7)});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 4'b0111, 4'b0111};
        tbl[1] = '{1'b1, 4'b0111, 4'b1110};
        tbl[2] = '{1'b0, 4'b1010, 4'b1010};
        tbl[3] = '{1'b1, 4'b1000, 4'b0001};
        tbl[4] = '{1'b1, 4'b0110, 4'b0110};
        tbl[5] = '{1'b0, 4'b1001, 4'b1001};

        // Reset held with load high and all-ones data.
        rst    = 1'b0;
        en     = 1'b1;
        load4m = 1'b1; d4m = 4'hF;
        load4l = 1'b1; d4l = 4'hF;
        load8  = 1'b1; d8  = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            check("rst_outs", {y8, yv8, ready8, busy8, y4m, yv4m, ready4m, busy4m, y4l, yv4l, ready4l, busy4l},
                  12'b0010_0010_0010);
        end
        @(posedge clk);
        #1;
        load4m = 1'b0; load4l = 1'b0; load8 = 1'b0;
        rst    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_after_rst", {yv8, busy8, yv4m, busy4m, yv4l, busy4l}, 6'b0);
        end
        @(posedge clk);
        #1;

        // Table-driven 4-bit words on both bit orders.
        for (int k = 0; k < 6; k++) begin
            if (tbl[k].lsb) begin
                d4l = tbl[k].d; load4l = 1'b1;
            end else begin
                d4m = tbl[k].d; load4m = 1'b1;
            end
            @(posedge clk);
            #1;
            load4m = 1'b0;
            load4l = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                exp4 = {1'b1, tbl[k].seq[3-i], (i == 0), (i == 3)};
                act4 = tbl[k].lsb ? {yv4l, y4l, first4l, last4l} : {yv4m, y4m, first4m, last4m};
                check("w4_bit", act4, exp4);
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            act4 = tbl[k].lsb ? {yv4l, y4l, busy4l, 1'b0} : {yv4m, y4m, busy4m, 1'b0};
            check("w4_idle", act4, 4'b0);
            @(posedge clk);
            #1;
        end

        // Back-to-back 8-bit words with load held high.
        fork
            begin
                send8(8'hA5);
                send8(8'h3C);
                send8(8'hFF);
                load8 = 1'b0;
            end
            begin
                bt = 0; bgap = 0; blow = 0;
                @(negedge clk);
                while (!yv8 && bt < 20) begin
                    bt++;
                    @(negedge clk);
                end
                for (int i = 0; i < 24; i++) begin
                    if (i > 0) @(negedge clk);
                    if (!yv8) bgap++;
                    if (!ready8) blow++;
                end
                check("b2b_gap", bgap, 0);
                check("b2b_ready_low", blow, 14);
                @(negedge clk);
                check("b2b_end", {yv8, busy8}, 2'b00);
            end
        join
        @(posedge clk);
        #1;

        // Stall: en low for 3 cycles while bit 2 is on y.
        send8(8'h81);
        load8 = 1'b0;
        vc    = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!yv8) break;
            vc++;
            if (vc >= 3 && vc <= 6)
                check("stall_hold", {y8, first8, last8, busy8}, 4'b0001);
            @(posedge clk);
            #1;
            en = !(vc >= 2 && vc <= 4);
        end
        check("stall_len", vc, 11);
        en = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-word with the holding buffer full.
        send8(8'hA5);
        send8(8'h5A);
        load8 = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("mid_pre", {yv8, ready8, busy8}, 3'b101);
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst", {y8, yv8, first8, ready8, busy8}, 5'b00010);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {yv8, busy8}, 2'b00);
        @(posedge clk);
        #1;
        send8(8'hC3);
        load8 = 1'b0;
        @(negedge clk);
        check("fresh_first", {yv8, first8}, 2'b11);
        bt = 0;
        while (busy8 && bt < 20) begin
            @(negedge clk);
            bt++;
        end
        check("fresh_done", {busy8, yv8}, 2'b00);
        check("sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
